rf_wr_port_arb: RTL

//  Shares the single register-file write port between the in-order writeback stage and a

---
 rtl/rf_wr_port_arb_if.sv | 25 ++
 rtl/rf_wr_port_arb.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/rf_wr_port_arb_if.sv
// Register-file write-port arbiter bus: WB request, LL request/handshake, RF write and hazard exports.
interface rf_wr_port_arb_if #(parameter int XLEN = 32);
    logic            wb_en_i;
    logic [4:0]      wb_reg_i;
    logic [XLEN-1:0] wb_data_i;
    logic            ll_valid_i;
    logic            ll_ready_o;
    logic [4:0]      ll_reg_i;
    logic [XLEN-1:0] ll_data_i;
    logic            rf_wr_en_o;
    logic [4:0]      rf_wr_reg_o;
    logic [XLEN-1:0] rf_wr_data_o;
    logic [31:0]     busy_o;
    logic            stall_req_o;
    logic            fwd_src_ll_o;

    modport slave (
        input  wb_en_i, wb_reg_i, wb_data_i, ll_valid_i, ll_reg_i, ll_data_i,
        output ll_ready_o, rf_wr_en_o, rf_wr_reg_o, rf_wr_data_o, busy_o, stall_req_o, fwd_src_ll_o
    );
    modport master (
        output wb_en_i, wb_reg_i, wb_data_i, ll_valid_i, ll_reg_i, ll_data_i,
        input  ll_ready_o, rf_wr_en_o, rf_wr_reg_o, rf_wr_data_o, busy_o, stall_req_o, fwd_src_ll_o
    );
endinterface

// File: rtl/rf_wr_port_arb.sv
// RF write-port arbiter: WB has priority, LL results queue in a FIFO and drain into idle slots.
// Define RF_ARB_STATS_EN to add the stall_cycles_o / ll_writes_o saturating counters.
module rf_wr_port_arb #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int XLEN         = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    rf_wr_port_arb_if.slave bus
`ifdef RF_ARB_STATS_EN
    ,
    output logic [15:0]   stall_cycles_o,
    output logic [15:0]   ll_writes_o
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;

    logic [4:0]      r_reg  [DEPTH];
    logic [XLEN-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [AW-1:0]   r_wptr, r_rptr;
    logic [AW:0]     r_cnt;
    state_t          r_state;
    logic [CW-1:0]   r_deny;
    logic            r_stall;

    logic            w_full, w_empty, w_wb_win, w_ll_grant, w_enq, w_denied;
    logic [AW:0]     w_cnt_nxt;
    logic [31:0]     w_busy;

    assign w_full     = (r_cnt == (AW+1)'(DEPTH));
    assign w_empty    = (r_cnt == '0);
    // Writes are suppressed during reset so a stale head never reaches the RF.
    assign w_wb_win   = !rst_i && bus.wb_en_i && (bus.wb_reg_i != 5'd0);
    assign w_ll_grant = !rst_i && !w_wb_win && !w_empty;
    assign w_denied   = !w_empty && !w_ll_grant;
    assign w_enq      = bus.ll_valid_i && !w_full && (bus.ll_reg_i != 5'd0);
    assign w_cnt_nxt  = r_cnt + (AW+1)'(w_enq) - (AW+1)'(w_ll_grant);

    assign bus.ll_ready_o  = !w_full;
    assign bus.stall_req_o = r_stall;
    assign bus.busy_o      = w_busy;

    always_comb begin
        bus.rf_wr_en_o   = 1'b0;
        bus.rf_wr_reg_o  = 5'd0;
        bus.rf_wr_data_o = '0;
        bus.fwd_src_ll_o = 1'b0;
        if (w_wb_win) begin
            bus.rf_wr_en_o   = 1'b1;
            bus.rf_wr_reg_o  = bus.wb_reg_i;
            bus.rf_wr_data_o = bus.wb_data_i;
        end else if (w_ll_grant) begin
            bus.rf_wr_en_o   = 1'b1;
            bus.rf_wr_reg_o  = r_reg[r_rptr];
            bus.rf_wr_data_o = r_data[r_rptr];
            bus.fwd_src_ll_o = 1'b1;
        end
    end

    always_comb begin
        w_busy = '0;
        for (int i = 0; i < DEPTH; i++)
            if (r_vld[i]) w_busy[r_reg[i]] = 1'b1;
        w_busy[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_vld  <= '0;
        end else begin
            if (w_enq) begin
                r_reg[r_wptr]  <= bus.ll_reg_i;
                r_data[r_wptr] <= bus.ll_data_i;
                r_vld[r_wptr]  <= 1'b1;
                r_wptr         <= r_wptr + AW'(1);
            end
            if (w_ll_grant) begin
                r_vld[r_rptr] <= 1'b0;
                r_rptr        <= r_rptr + AW'(1);
            end
            r_cnt <= w_cnt_nxt;
        end
    end

    // Starvation FSM: stall_req_o is registered and follows the FORCE state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_deny  <= '0;
            r_stall <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_cnt_nxt != '0) r_state <= WAIT;
                end
                WAIT: begin
                    if (w_cnt_nxt == '0) begin
                        r_state <= IDLE;
                        r_deny  <= '0;
                    end else if ((w_denied && r_deny == CW'(STARVE_LIMIT - 1)) || w_full) begin
                        r_state <= FORCE;
                        r_deny  <= '0;
                        r_stall <= 1'b1;
                    end else if (w_denied) begin
                        r_deny <= r_deny + CW'(1);
                    end else begin
                        r_deny <= '0;
                    end
                end
                FORCE: begin
                    if (w_cnt_nxt == '0) begin
                        r_state <= IDLE;
                        r_deny  <= '0;
                        r_stall <= 1'b0;
                    end else if (w_ll_grant) begin
                        r_deny <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_deny  <= '0;
                    r_stall <= 1'b0;
                end
            endcase
        end
    end

`ifdef RF_ARB_STATS_EN
    logic [15:0] r_stall_cyc, r_ll_wr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cyc <= '0;
            r_ll_wr     <= '0;
        end else begin
            if (r_stall && r_stall_cyc != 16'hFFFF)   r_stall_cyc <= r_stall_cyc + 16'd1;
            if (w_ll_grant && r_ll_wr != 16'hFFFF)    r_ll_wr     <= r_ll_wr + 16'd1;
        end
    end

    assign stall_cycles_o = r_stall_cyc;
    assign ll_writes_o    = r_ll_wr;
`endif
endmodule
